// File: rtl/read_write_logic.sv
// CPU bus front end for the 8259-style interrupt controller: latches write data and decodes
// each completed write into a single command-word strobe, and tracks CPU read cycles.
module read_write_logic (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_in,
  input  logic       write_in,
  input  logic       chipSelect,
  input  logic       A0In,
  input  logic [7:0] inDataBus,
  output logic       writeICW1,
  output logic       writeICW2to4,
  output logic       writeOCW1,
  output logic       writeOCW2,
  output logic       writeOCW3,
  output logic       read_flag,
  output logic [7:0] internalDataBus
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } init_state_t;

  init_state_t r_state, w_state_next;

  logic       w_wr_act, w_rd_act, w_commit;
  logic       r_wr_hist;
  logic       r_a0;
  logic [7:0] r_data;
  logic       r_sngl, r_ic4, w_sngl_next, w_ic4_next;
  logic       r_icw1, r_icw2to4, r_ocw1, r_ocw2, r_ocw3, r_read_flag;
  logic       w_icw1, w_icw2to4, w_ocw1, w_ocw2, w_ocw3;

  assign w_wr_act = ~chipSelect & ~write_in;
  assign w_rd_act = ~chipSelect & ~read_in;
  // A write is committed on the first edge after it ends, using the last latched byte.
  assign w_commit = r_wr_hist & ~w_wr_act;

  always_comb begin
    w_state_next = r_state;
    w_sngl_next  = r_sngl;
    w_ic4_next   = r_ic4;
    w_icw1       = 1'b0;
    w_icw2to4    = 1'b0;
    w_ocw1       = 1'b0;
    w_ocw2       = 1'b0;
    w_ocw3       = 1'b0;
    if (w_commit) begin
      if (!r_a0) begin
        if (r_data[4]) begin
          w_icw1       = 1'b1;
          w_state_next = WAIT_ICW2;
          w_sngl_next  = r_data[1];
          w_ic4_next   = r_data[0];
        end else if (!r_data[3]) begin
          w_ocw2 = 1'b1;
        end else begin
          w_ocw3 = 1'b1;
        end
      end else if (r_state != READY) begin
        w_icw2to4 = 1'b1;
        case (r_state)
          WAIT_ICW2: begin
            if (!r_sngl)    w_state_next = WAIT_ICW3;
            else if (r_ic4) w_state_next = WAIT_ICW4;
            else            w_state_next = READY;
          end
          WAIT_ICW3: w_state_next = r_ic4 ? WAIT_ICW4 : READY;
          default:   w_state_next = READY;
        endcase
      end else begin
        w_ocw1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= READY;
      r_sngl      <= 1'b0;
      r_ic4       <= 1'b0;
      r_wr_hist   <= 1'b0;
      r_a0        <= 1'b0;
      r_data      <= 8'h00;
      r_icw1      <= 1'b0;
      r_icw2to4   <= 1'b0;
      r_ocw1      <= 1'b0;
      r_ocw2      <= 1'b0;
      r_ocw3      <= 1'b0;
      r_read_flag <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sngl      <= w_sngl_next;
      r_ic4       <= w_ic4_next;
      r_wr_hist   <= w_wr_act;
      if (w_wr_act) begin
        r_a0   <= A0In;
        r_data <= inDataBus;
      end
      r_icw1      <= w_icw1;
      r_icw2to4   <= w_icw2to4;
      r_ocw1      <= w_ocw1;
      r_ocw2      <= w_ocw2;
      r_ocw3      <= w_ocw3;
      r_read_flag <= w_rd_act & ~w_wr_act;
    end
  end

  assign writeICW1       = r_icw1;
  assign writeICW2to4    = r_icw2to4;
  assign writeOCW1       = r_ocw1;
  assign writeOCW2       = r_ocw2;
  assign writeOCW3       = r_ocw3;
  assign read_flag       = r_read_flag;
  assign internalDataBus = r_data;

endmodule

// File: tb/tb_read_write_logic.sv
// Directed bench for read_write_logic; strobes are checked as {ICW1, ICW2to4, OCW1, OCW2, OCW3}.
module tb_read_write_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read_in = 1'b1;
  logic       write_in = 1'b1;
  logic       chipSelect = 1'b1;
  logic       A0In = 1'b0;
  logic [7:0] inDataBus = 8'h00;
  logic       writeICW1, writeICW2to4, writeOCW1, writeOCW2, writeOCW3, read_flag;
  logic [7:0] internalDataBus;
  logic [4:0] w_strb;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_ICW1 = 5'b10000;
  localparam logic [4:0] S_ICW2 = 5'b01000;
  localparam logic [4:0] S_OCW1 = 5'b00100;
  localparam logic [4:0] S_OCW2 = 5'b00010;
  localparam logic [4:0] S_OCW3 = 5'b00001;

  read_write_logic dut (
    .clk            (clk),
    .rst            (rst),
    .read_in        (read_in),
    .write_in       (write_in),
    .chipSelect     (chipSelect),
    .A0In           (A0In),
    .inDataBus      (inDataBus),
    .writeICW1      (writeICW1),
    .writeICW2to4   (writeICW2to4),
    .writeOCW1      (writeOCW1),
    .writeOCW2      (writeOCW2),
    .writeOCW3      (writeOCW3),
    .read_flag      (read_flag),
    .internalDataBus(internalDataBus)
  );

  assign w_strb = {writeICW1, writeICW2to4, writeOCW1, writeOCW2, writeOCW3};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write held for `hold` edges, then released; checks latch, single pulse, and pulse end.
  task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                          input logic [4:0] exp, input int hold);
    chipSelect = 1'b0; write_in = 1'b0; A0In = a0; inDataBus = d;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_nostrb_during"}, {3'b0, w_strb}, {3'b0, S_NONE});
    end
    chipSelect = 1'b1; write_in = 1'b1; inDataBus = ~d;
    chk({tag, "_bus"}, internalDataBus, d);
    tick();
    chk({tag, "_strb"}, {3'b0, w_strb}, {3'b0, exp});
    chk({tag, "_bus_hold"}, internalDataBus, d);
    tick();
    chk({tag, "_strb_end"}, {3'b0, w_strb}, {3'b0, S_NONE});
  endtask

  initial begin
    // Reset with a write and read active: nothing may leak out.
    chipSelect = 1'b0; write_in = 1'b0; read_in = 1'b0; A0In = 1'b0; inDataBus = 8'h13;
    tick();
    tick();
    chk("rst_strb", {3'b0, w_strb}, 8'h00);
    chk("rst_bus", internalDataBus, 8'h00);
    chk("rst_rdflag", {7'b0, read_flag}, 8'h00);
    rst = 1'b0; chipSelect = 1'b1; write_in = 1'b1; read_in = 1'b1;
    tick();
    chk("post_rst_nostrb", {3'b0, w_strb}, 8'h00);
    chk("post_rst_bus", internalDataBus, 8'h00);

    do_write("ocw1_ff", 1'b1, 8'hFF, S_OCW1, 1);

    // Cascade init without ICW4
    do_write("icw1_10", 1'b0, 8'h10, S_ICW1, 1);
    do_write("icw2_20", 1'b1, 8'h20, S_ICW2, 1);
    do_write("icw3_04", 1'b1, 8'h04, S_ICW2, 1);
    do_write("ocw1_fe", 1'b1, 8'hFE, S_OCW1, 1);

    // Single mode with ICW4: ICW3 skipped
    do_write("icw1_13", 1'b0, 8'h13, S_ICW1, 1);
    do_write("icw2_08", 1'b1, 8'h08, S_ICW2, 1);
    do_write("icw4_01", 1'b1, 8'h01, S_ICW2, 1);
    do_write("ocw1_55", 1'b1, 8'h55, S_OCW1, 1);

    // OCW2 in the middle of an init sequence leaves the sequence state alone
    do_write("icw1_10b", 1'b0, 8'h10, S_ICW1, 1);
    do_write("mid_ocw2", 1'b0, 8'h20, S_OCW2, 1);
    do_write("icw2_mid", 1'b1, 8'h30, S_ICW2, 1);
    do_write("icw3_mid", 1'b1, 8'h02, S_ICW2, 1);
    do_write("ocw1_aa", 1'b1, 8'hAA, S_OCW1, 1);

    // OCW decode
    do_write("ocw2_20", 1'b0, 8'h20, S_OCW2, 1);
    do_write("ocw3_08", 1'b0, 8'h08, S_OCW3, 1);
    do_write("ocw3_0b", 1'b0, 8'h0B, S_OCW3, 1);

    // Chip select gating: write strobe without chip select is ignored
    chipSelect = 1'b1; write_in = 1'b0; A0In = 1'b0; inDataBus = 8'h10;
    tick();
    tick();
    chk("cs_gate_bus", internalDataBus, 8'h0B);
    write_in = 1'b1;
    tick();
    chk("cs_gate_strb1", {3'b0, w_strb}, 8'h00);
    tick();
    chk("cs_gate_strb2", {3'b0, w_strb}, 8'h00);

    // Long write: one strobe only
    do_write("hold3_77", 1'b1, 8'h77, S_OCW1, 3);

    // Read cycles
    chipSelect = 1'b0; read_in = 1'b0;
    chk("rd_pre", {7'b0, read_flag}, 8'h00);
    tick();
    chk("rd_c1", {7'b0, read_flag}, 8'h01);
    tick();
    chk("rd_c2", {7'b0, read_flag}, 8'h01);
    chipSelect = 1'b1; read_in = 1'b1;
    tick();
    chk("rd_end", {7'b0, read_flag}, 8'h00);
    chk("rd_bus_kept", internalDataBus, 8'h77);
    read_in = 1'b0;
    tick();
    chk("rd_nocs", {7'b0, read_flag}, 8'h00);
    read_in = 1'b1;

    // Read and write together: write wins
    chipSelect = 1'b0; read_in = 1'b0; write_in = 1'b0; A0In = 1'b1; inDataBus = 8'h3C;
    tick();
    chk("rdwr_flag", {7'b0, read_flag}, 8'h00);
    chk("rdwr_bus", internalDataBus, 8'h3C);
    chipSelect = 1'b1; read_in = 1'b1; write_in = 1'b1;
    tick();
    chk("rdwr_strb", {3'b0, w_strb}, {3'b0, S_OCW1});
    tick();
    chk("rdwr_strb_end", {3'b0, w_strb}, 8'h00);

    // Reset mid-write: no strobe afterwards
    chipSelect = 1'b0; write_in = 1'b0; A0In = 1'b1; inDataBus = 8'h99;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; chipSelect = 1'b1; write_in = 1'b1;
    chk("rst_mid_bus", internalDataBus, 8'h00);
    tick();
    chk("rst_mid_strb", {3'b0, w_strb}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_write_logic.md
# read_write_logic

Bus-interface front end of the 8259-compatible interrupt controller. Samples the active-low CPU strobes (chip select, read, write), address line A0 and the 8-bit CPU data bus. Decodes each completed write into exactly one command-word strobe (ICW1, ICW2–4, OCW1, OCW2, OCW3) and drives the latched byte onto the internal data bus. Also flags CPU read cycles for the status/readback logic. Sits between the CPU pins and the init/control-register blocks.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `read_in`  in  1  CPU read strobe, active low.
- `write_in`  in  1  CPU write strobe, active low.
- `chipSelect`  in  1  chip select, active low.
- `A0In`  in  1  address bit A0.
- `inDataBus`  in  8  CPU data bus (write data).
- `writeICW1`  out  1  one-cycle pulse: ICW1 written.
- `writeICW2to4`  out  1  one-cycle pulse: ICW2, ICW3 or ICW4 written.
- `writeOCW1`  out  1  one-cycle pulse: OCW1 (mask) written.
- `writeOCW2`  out  1  one-cycle pulse: OCW2 written.
- `writeOCW3`  out  1  one-cycle pulse: OCW3 written.
- `read_flag`  out  1  registered level: CPU read cycle in progress.
- `internalDataBus`  out  8  last latched write byte.

## Operation
- `wr_act = !chipSelect & !write_in`; `rd_act = !chipSelect & !read_in`. Strobes with `chipSelect` high are ignored.
- **Latch:** every rising edge with `wr_act=1` loads `internalDataBus <= inDataBus` and stores A0. The last sampled active cycle wins.
- **Commit:** on the first edge where `wr_act=0` after an edge with `wr_act=1`, decode the latched A0/byte and pulse exactly one strobe:
  - A0=0, D4=1 → `writeICW1`. Captures SNGL=D1 and IC4=D0. Sequence state becomes WAIT_ICW2, even if an init sequence is already in progress (restart).
  - A0=0, D4=0, D3=0 → `writeOCW2`.
  - A0=0, D4=0, D3=1 → `writeOCW3`.
  - A0=1 with sequence state ≠ READY → `writeICW2to4`, then advance the state.
  - A0=1 with state READY → `writeOCW1`.
- **Init sequence states:** READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
  - WAIT_ICW2 → WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
  - WAIT_ICW3 → WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4 → READY.
- OCW2/OCW3 writes during an init sequence still decode as OCW2/OCW3 and leave the sequence state unchanged.
- `read_flag <= rd_act & !wr_act`. When read and write are both active, write wins and `read_flag=0`.
- Reads do not change `internalDataBus` or the sequence state.

## Timing
- **Reset** (`rst=1` at an edge): all strobes 0, `read_flag=0`, `internalDataBus=8'h00`, state READY, SNGL=0, IC4=0, write-history flop cleared. Reset overrides any write or read in progress. A write interrupted by reset produces no strobe.
- **Strobe latency:** the strobe is high for exactly one clock, during the cycle after the first edge that samples `wr_act=0`.
- **Data latency:** `internalDataBus` is valid from the first edge sampling `wr_act=1` and holds until the next write. It is therefore stable while the strobe is high.
- **Strobe width:** a write must be held for at least one sampling edge to be seen. A write held for N edges yields one strobe, not N.
- Two writes separated by at least one inactive edge yield two strobes.
- At most one command strobe is high in any cycle.
- **read_flag latency:** one clock; it follows `rd_act`.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with strobes active → all outputs 0, `internalDataBus=00`. After release, write A0=1 data `FF` → `writeOCW1` pulses, bus=`FF`.
- **Init, cascade mode:** write ICW1 `10` (A0=0), then A0=1 `20`, then A0=1 `04` → `writeICW1`, then `writeICW2to4` twice. Next A0=1 `FE` → `writeOCW1`.
- **Init with ICW4:** write ICW1 `13` (SNGL=1, IC4=1), then A0=1 `08`, `01`, `55` → ICW1, ICW2to4, ICW2to4, then OCW1 (ICW3 skipped).
- **OCW decode:** A0=0 `20` → `writeOCW2`. A0=0 `08` → `writeOCW3`. A0=0 `0B` → `writeOCW3`, bus=`0B`.
- **Chip select gating:** `write_in=0` with `chipSelect=1`, data `10` → no strobe, bus unchanged. Write held low for 3 cycles → single one-cycle strobe.
- **Read:** `chipSelect=0`, `read_in=0` for 2 cycles → `read_flag=1` for 2 cycles, delayed by one clock. `chipSelect=1`, `read_in=0` → `read_flag=0`. Read with write active → `read_flag=0`.
